// File: rtl/button_debounce_pkg.sv
// Shared constants and helpers for the button debouncer.
// Defaults target a 50 MHz clock with a 1 ms settle window.
package button_debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned WIDTH_DEFAULT = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// One debounced button channel: synchronizer, settle counter,
// accepted level and registered press/release pulses.
module button_debounce_bit
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter bit INVERT = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic clean,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic sample;
  logic [CW-1:0] cnt;

  assign sample = sync2 ^ INVERT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
      cnt   <= '0;
      clean <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (sample == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // full run of differing samples: accept the new level
        clean <= sample;
        cnt   <= '0;
        press <= sample;
        rel   <= ~sample;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer: one independent channel per pin,
// polarity fixed at elaboration.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] btn_clean,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  // a released pin idles at 1 when active-low, else at 0
  localparam bit IDLE = ACTIVE_LOW;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    button_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE),
      .INVERT         (ACTIVE_LOW)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (button_raw[i]),
      .clean  (btn_clean[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i])
    );
  end

endmodule
